// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the request port, the ALU calc/calc_done port and the response port
// between the sequencer, alu_issue_ctrl and the ALU.
//
// Handshake semantics for req_* and rsp_*: a transfer happens on the rising clock
// edge where both valid and ready are 1. Once valid is raised, the payload stays
// stable and valid stays high until that transfer edge. ready may be asserted
// before valid and carries no obligation on its own.
interface alu_issue_ctrl_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [4:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;

    logic [31:0]      alu_operand_a;
    logic [31:0]      alu_operand_b;
    logic [4:0]       alu_operation;
    logic             alu_calc;
    logic [31:0]      alu_result;
    logic             alu_calc_done;
    logic [4:0]       alu_flags;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [4:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    // Controller side
    modport master (
        input  req_valid, req_op, req_a, req_b, req_tag,
        input  alu_result, alu_calc_done, alu_flags,
        input  rsp_ready,
        output req_ready,
        output alu_operand_a, alu_operand_b, alu_operation, alu_calc,
        output rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err
    );

    // Sequencer/ALU side
    modport slave (
        output req_valid, req_op, req_a, req_b, req_tag,
        output alu_result, alu_calc_done, alu_flags,
        output rsp_ready,
        input  req_ready,
        input  alu_operand_a, alu_operand_b, alu_operation, alu_calc,
        input  rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one ALU operation at a time: latches the request, holds calc until the ALU
// samples it, waits for calc_done, and returns result/flags/tag on the response port.
// A watchdog abandons an op that sits in ISSUE+WAIT too long and reports rsp_err.
module alu_issue_ctrl #(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_issue_ctrl_if.master     bus,
    output logic [15:0]          timeout_count,
    output logic [1:0]           dbg_state
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [TMR_W-1:0] timer;
    logic [TAG_W-1:0] tag_q;
    logic             accept;
    logic             finish_ok;
    logic             finish_to;
    logic             timer_inc;
    logic             rsp_take;

    assign rsp_take  = bus.rsp_valid & bus.rsp_ready;
    assign dbg_state = state;

    // State register; reset drops alu_calc immediately since it decodes from state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake outputs and datapath strobes
    always_comb begin
        state_next    = state;
        bus.req_ready = 1'b0;
        bus.alu_calc  = 1'b0;
        accept        = 1'b0;
        finish_ok     = 1'b0;
        finish_to     = 1'b0;
        timer_inc     = 1'b0;
        case (state)
            IDLE: begin
                // A pending response blocks new work: only one op is ever in flight
                bus.req_ready = ~bus.rsp_valid;
                if (bus.req_valid && !bus.rsp_valid) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                bus.alu_calc = 1'b1;
                // calc_done high while calc is high means the ALU took the op
                if (bus.alu_calc_done) begin
                    state_next = WAIT;
                end else if (timer == TMR_LIMIT) begin
                    finish_to  = 1'b1;
                    state_next = IDLE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            WAIT: begin
                // Completion takes priority over a timeout on the same edge
                if (bus.alu_calc_done) begin
                    finish_ok  = 1'b1;
                    state_next = IDLE;
                end else if (timer == TMR_LIMIT) begin
                    finish_to  = 1'b1;
                    state_next = IDLE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand/tag latch, watchdog timer, response registers and timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_operand_a <= '0;
            bus.alu_operand_b <= '0;
            bus.alu_operation <= '0;
            tag_q             <= '0;
            timer             <= '0;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_result    <= '0;
            bus.rsp_flags     <= '0;
            bus.rsp_tag       <= '0;
            bus.rsp_err       <= 1'b0;
            timeout_count     <= '0;
        end else begin
            if (accept) begin
                bus.alu_operand_a <= bus.req_a;
                bus.alu_operand_b <= bus.req_b;
                bus.alu_operation <= bus.req_op;
                tag_q             <= bus.req_tag;
                timer             <= '0;
            end else if (timer_inc) begin
                timer <= timer + 1'b1;
            end

            if (finish_ok) begin
                bus.rsp_valid  <= 1'b1;
                bus.rsp_result <= bus.alu_result;
                bus.rsp_flags  <= bus.alu_flags;
                bus.rsp_tag    <= tag_q;
                bus.rsp_err    <= 1'b0;
            end else if (finish_to) begin
                bus.rsp_valid  <= 1'b1;
                bus.rsp_result <= '0;
                bus.rsp_flags  <= '0;
                bus.rsp_tag    <= tag_q;
                bus.rsp_err    <= 1'b1;
                if (timeout_count != 16'hFFFF) begin
                    timeout_count <= timeout_count + 16'd1;
                end
            end else if (rsp_take) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU (add/sub, programmable
// latency, stuck mode) and a scoreboard of expected {err, tag, flags, result}.
module tb_alu_issue_ctrl;

    localparam int TB_TIMEOUT = 16;
    localparam int RW         = 42;   // {err, tag[3:0], flags[4:0], result[31:0]}

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] timeout_count;
    logic [1:0]  dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    logic [RW-1:0] exp_q[$];

    alu_issue_ctrl_if #(.TAG_W(4)) bus ();

    alu_issue_ctrl #(
        .TAG_W          (4),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .timeout_count (timeout_count),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, observed hang expected finish");
        $fatal(1, "global timeout");
    end

    // ---------------- behavioural ALU ----------------
    // Reference arithmetic: flags are {ltz, gtz, zero, overflow, carry}
    function automatic logic [36:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [32:0] s;
        logic        ov;
        logic [31:0] r;
        logic [4:0]  f;
        if (op == 5'd1) begin
            s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
            ov = (a[31] != b[31]) && (s[31] != a[31]);
        end else begin
            s  = {1'b0, a} + {1'b0, b};
            ov = (a[31] == b[31]) && (s[31] != a[31]);
        end
        r = s[31:0];
        f = {r[31], (!r[31]) && (r != 32'd0), (r == 32'd0), ov, s[32]};
        return {f, r};
    endfunction

    logic [31:0] alu_res   = '0;
    logic [4:0]  alu_flg   = '0;
    int          alu_busy  = 0;
    int          alu_lat   = 0;
    bit          alu_stuck = 1'b0;

    assign bus.alu_calc_done = !alu_stuck && (alu_busy == 0);
    assign bus.alu_result    = alu_res;
    assign bus.alu_flags     = alu_flg;

    always @(posedge clk) begin
        if (bus.alu_calc && bus.alu_calc_done) begin
            {alu_flg, alu_res} <= alu_fn(bus.alu_operation, bus.alu_operand_a, bus.alu_operand_b);
            alu_busy           <= alu_lat;
        end else if (alu_busy > 0) begin
            alu_busy <= alu_busy - 1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [RW-1:0] rsp_pack();
        return {bus.rsp_err, bus.rsp_tag, bus.rsp_flags, bus.rsp_result};
    endfunction

    // ---------------- driver tasks ----------------
    // Presents a request, waits for acceptance, pushes its expected response.
    // Returns #1 after the accept edge.
    task automatic send_req(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] tag, input logic [RW-1:0] exp);
        int cyc = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        while (!bus.req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 50) check("req_accept_wait", {63'd0, bus.req_ready}, 64'd1);
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Waits for rsp_valid, counting edges from the caller's current cycle.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!bus.rsp_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!bus.rsp_valid) check("rsp_valid_wait", {63'd0, bus.rsp_valid}, 64'd1);
    endtask

    // Compares the presented response with the scoreboard head, then takes it.
    task automatic get_rsp(input string tag);
        int cyc;
        logic [RW-1:0] exp;
        wait_valid(cyc);
        if (bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
            end else begin
                exp = exp_q.pop_front();
                check(tag, 64'(rsp_pack()), 64'(exp));
            end
            @(negedge clk);
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.rsp_ready = 1'b0;
        end
    endtask

    function automatic logic [RW-1:0] model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [3:0] tag);
        return {1'b0, tag, alu_fn(op, a, b)};
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        bit stable_ok;
        logic [RW-1:0] held;

        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_alu_calc",   {63'd0, bus.alu_calc},   64'd0);
        check("rst_rsp_valid",  {63'd0, bus.rsp_valid},  64'd0);
        check("rst_timeouts",   {48'd0, timeout_count},  64'd0);
        check("rst_operand_a",  {32'd0, bus.alu_operand_a}, 64'd0);
        check("rst_state",      {62'd0, dbg_state},      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_req_ready", {63'd0, bus.req_ready},  64'd1);

        // 1: add 5+7, single-cycle ALU, latency check
        alu_lat = 0;
        send_req(5'd0, 32'd5, 32'd7, 4'd3, {1'b0, 4'd3, 5'b01000, 32'd12});
        check("t1_calc_t0",     {63'd0, bus.alu_calc},   64'd1);
        check("t1_ready_busy",  {63'd0, bus.req_ready},  64'd0);
        @(posedge clk);
        #1;
        check("t1_calc_t1",     {63'd0, bus.alu_calc},   64'd0);
        check("t1_valid_t1",    {63'd0, bus.rsp_valid},  64'd0);
        @(posedge clk);
        #1;
        check("t1_valid_t2",    {63'd0, bus.rsp_valid},  64'd1);
        get_rsp("t1_add_rsp");
        check("t1_ready_after", {63'd0, bus.req_ready},  64'd1);

        // 2: signed overflow on add
        send_req(5'd0, 32'h7FFF_FFFF, 32'd1, 4'd9, {1'b0, 4'd9, 5'b10010, 32'h8000_0000});
        get_rsp("t2_ovf_rsp");

        // 3: ten-cycle ALU op, operands held throughout
        alu_lat = 10;
        send_req(5'd1, 32'd1000, 32'd1, 4'd4, model(5'd1, 32'd1000, 32'd1, 4'd4));
        cyc       = 0;
        stable_ok = 1'b1;
        while (!bus.rsp_valid && cyc < 40) begin
            stable_ok &= (bus.alu_operand_a === 32'd1000) && (bus.alu_operand_b === 32'd1)
                         && (bus.alu_operation === 5'd1);
            @(posedge clk);
            #1;
            cyc++;
        end
        check("t3_latency",        64'(cyc), 64'd12);
        check("t3_operands_stable", {63'd0, stable_ok}, 64'd1);
        get_rsp("t3_slow_rsp");
        alu_lat = 0;

        // 4: ALU never completes -> watchdog response
        alu_stuck = 1'b1;
        send_req(5'd0, 32'd11, 32'd22, 4'd6, {1'b1, 4'd6, 5'd0, 32'd0});
        wait_valid(cyc);
        check("t4_latency",      64'(cyc), 64'(TB_TIMEOUT));
        check("t4_timeouts",     {48'd0, timeout_count}, 64'd1);
        check("t4_ready_hold",   {63'd0, bus.req_ready}, 64'd0);
        alu_stuck = 1'b0;
        get_rsp("t4_timeout_rsp");
        check("t4_ready_after",  {63'd0, bus.req_ready}, 64'd1);

        // 5: response back-pressure with a second request waiting
        send_req(5'd0, 32'hFFFF_FFFF, 32'd1, 4'd5, model(5'd0, 32'hFFFF_FFFF, 32'd1, 4'd5));
        wait_valid(cyc);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 5'd1;
        bus.req_a     = 32'd3;
        bus.req_b     = 32'd8;
        bus.req_tag   = 4'd12;
        held      = exp_q[0];
        stable_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            stable_ok &= (rsp_pack() === held) && (bus.rsp_valid === 1'b1)
                         && (bus.req_ready === 1'b0);
        end
        check("t5_hold_stable", {63'd0, stable_ok}, 64'd1);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        check("t5_ready_take_cycle", {63'd0, bus.req_ready}, 64'd0);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        void'(exp_q.pop_front());
        check("t5_valid_dropped", {63'd0, bus.rsp_valid}, 64'd0);
        check("t5_ready_rises",   {63'd0, bus.req_ready}, 64'd1);
        @(posedge clk);
        exp_q.push_back(model(5'd1, 32'd3, 32'd8, 4'd12));
        #1;
        bus.req_valid = 1'b0;
        check("t5_accepted_state", {62'd0, dbg_state}, 64'd1);
        check("t5_accepted_opa",   {32'd0, bus.alu_operand_a}, 64'd3);
        get_rsp("t5_second_rsp");

        // 6: reset while waiting on a slow op
        alu_lat = 10;
        send_req(5'd0, 32'd40, 32'd2, 4'd7, model(5'd0, 32'd40, 32'd2, 4'd7));
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("t6_in_wait", {62'd0, dbg_state}, 64'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_front());
        check("t6_rst_calc",     {63'd0, bus.alu_calc},  64'd0);
        check("t6_rst_valid",    {63'd0, bus.rsp_valid}, 64'd0);
        check("t6_rst_state",    {62'd0, dbg_state},     64'd0);
        check("t6_rst_timeouts", {48'd0, timeout_count}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        alu_lat = 0;
        send_req(5'd1, 32'd9, 32'd9, 4'd2, model(5'd1, 32'd9, 32'd9, 4'd2));
        get_rsp("t6_after_reset_rsp");

        // Mixed traffic with random operands and latencies
        for (int i = 0; i < 6; i++) begin
            logic [4:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op      = 5'($urandom_range(0, 1));
            a       = $urandom;
            b       = $urandom;
            alu_lat = $urandom_range(0, 3);
            send_req(op, a, b, 4'(i + 8), model(op, a, b, 4'(i + 8)));
            get_rsp("rand_rsp");
        end
        check("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
